// File: rtl/mac_window_sequencer.sv
// mac_window_sequencer: computes a 3x3 convolution per window, one tap per
// cycle, by time-multiplexing one external combinational MAC.
//
// Ports:
//   Clk_i, Reset_n_i          clock, synchronous active-low reset
//   Window_i, Valid_i/Ready_o 3x3 pixel window in (tap k = row*3+col)
//   CoefWe_i/Addr_i/Data_i    coefficient bank write port (IDLE only)
//   Mult1_o/Mult2_o/Accum_o   operands to the external MAC
//   MacResult_i               MAC result (ACCUM_SIZE+1 bits, signed)
//   Acc_o, Pixel_o            saturated sum and clipped magnitude
//   Valid_o/Ready_i           result handshake
//   Busy_o                    high while a window is in flight
module mac_window_sequencer #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned MULT_SIZE  = 9,
  parameter int unsigned ACCUM_SIZE = 20
) (
  input  logic                    Clk_i,
  input  logic                    Reset_n_i,
  input  logic [9*PIX_W-1:0]      Window_i,
  input  logic                    Valid_i,
  output logic                    Ready_o,
  input  logic                    CoefWe_i,
  input  logic [3:0]              CoefAddr_i,
  input  logic [MULT_SIZE-1:0]    CoefData_i,
  output logic [MULT_SIZE-1:0]    Mult1_o,
  output logic [MULT_SIZE-1:0]    Mult2_o,
  output logic [ACCUM_SIZE-1:0]   Accum_o,
  input  logic [ACCUM_SIZE:0]     MacResult_i,
  output logic [ACCUM_SIZE-1:0]   Acc_o,
  output logic [PIX_W-1:0]        Pixel_o,
  output logic                    Valid_o,
  input  logic                    Ready_i,
  output logic                    Busy_o
);

  localparam int unsigned NTAPS = 9;
  localparam int unsigned TAP_W = 4;
  localparam int unsigned ZEXT_W = MULT_SIZE - PIX_W;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NTAPS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Sobel-X reset coefficients
  function automatic logic [MULT_SIZE-1:0] coef_default(input int unsigned k);
    case (k)
      0, 6:    coef_default = MULT_SIZE'(-1);
      2, 8:    coef_default = MULT_SIZE'(1);
      3:       coef_default = MULT_SIZE'(-2);
      5:       coef_default = MULT_SIZE'(2);
      default: coef_default = '0;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic                    ready_c, accept_c, coef_wr_c;
  logic [TAP_W-1:0]        tap_q, nk_c;
  logic [9*PIX_W-1:0]      win_q;
  logic [MULT_SIZE-1:0]    coef_q [NTAPS];
  logic [MULT_SIZE-1:0]    mult1_q, mult2_q;
  logic [ACCUM_SIZE-1:0]   accum_q, acc_out_q, acc_sat_c;
  logic [PIX_W-1:0]        pix_q, pix_c, nxt_pix_c;
  logic [MULT_SIZE-1:0]    coef0_c, nxt_coef_c;
  logic [ACCUM_SIZE:0]     acc_ext_c, mag_c;
  logic                    valid_q, busy_q;

  assign Ready_o = ready_c;
  assign Mult1_o = mult1_q;
  assign Mult2_o = mult2_q;
  assign Accum_o = accum_q;
  assign Acc_o   = acc_out_q;
  assign Pixel_o = pix_q;
  assign Valid_o = valid_q;
  assign Busy_o  = busy_q;

  // State register
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Next state and handshake decode
  always_comb begin
    state_d   = state_q;
    ready_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (Valid_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (tap_q == LAST_TAP) state_d = S_OUT;
      end
      S_OUT: begin
        ready_c = Ready_i;
        if (Ready_i) state_d = Valid_i ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    accept_c  = Valid_i & ready_c;
    coef_wr_c = (state_q == S_IDLE) & CoefWe_i & (CoefAddr_i < TAP_W'(NTAPS));
  end

  // Operand fetch, saturation and magnitude clip
  always_comb begin
    nk_c       = (tap_q == LAST_TAP) ? '0 : tap_q + TAP_W'(1);
    nxt_pix_c  = win_q[PIX_W*nk_c +: PIX_W];
    nxt_coef_c = coef_q[nk_c];
    // a write accepted together with the window must reach tap 0 directly
    coef0_c    = (coef_wr_c && CoefAddr_i == '0) ? CoefData_i : coef_q[0];
    // overflow when the two top bits of the MAC result disagree
    if (MacResult_i[ACCUM_SIZE] != MacResult_i[ACCUM_SIZE-1])
      acc_sat_c = {MacResult_i[ACCUM_SIZE], {(ACCUM_SIZE-1){~MacResult_i[ACCUM_SIZE]}}};
    else
      acc_sat_c = MacResult_i[ACCUM_SIZE-1:0];
    // one extra bit so the most-negative value has a representable magnitude
    acc_ext_c = {acc_sat_c[ACCUM_SIZE-1], acc_sat_c};
    mag_c     = acc_ext_c[ACCUM_SIZE] ? -acc_ext_c : acc_ext_c;
    pix_c     = (|mag_c[ACCUM_SIZE:PIX_W]) ? '1 : mag_c[PIX_W-1:0];
  end

  // Datapath, coefficient bank and registered status
  always_ff @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      tap_q     <= '0;
      win_q     <= '0;
      mult1_q   <= '0;
      mult2_q   <= '0;
      accum_q   <= '0;
      acc_out_q <= '0;
      pix_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      for (int unsigned k = 0; k < NTAPS; k++) coef_q[k] <= coef_default(k);
    end else begin
      valid_q <= (state_d == S_OUT);
      busy_q  <= (state_d != S_IDLE);
      if (coef_wr_c) coef_q[CoefAddr_i] <= CoefData_i;
      if (accept_c) begin
        win_q   <= Window_i;
        tap_q   <= '0;
        mult1_q <= {{ZEXT_W{1'b0}}, Window_i[PIX_W-1:0]};
        mult2_q <= coef0_c;
        accum_q <= '0;
      end else if (state_q == S_RUN) begin
        if (tap_q == LAST_TAP) begin
          tap_q     <= '0;
          mult1_q   <= '0;
          mult2_q   <= '0;
          accum_q   <= '0;
          acc_out_q <= acc_sat_c;
          pix_q     <= pix_c;
        end else begin
          tap_q   <= nk_c;
          mult1_q <= {{ZEXT_W{1'b0}}, nxt_pix_c};
          mult2_q <= nxt_coef_c;
          accum_q <= acc_sat_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_window_sequencer.sv
// Self-checking bench for mac_window_sequencer with an external MAC model.
module tb_mac_window_sequencer;

  localparam int PIX_W      = 8;
  localparam int MULT_SIZE  = 9;
  localparam int ACCUM_SIZE = 20;
  localparam int ACC_MAX    = 524287;
  localparam int ACC_MIN    = -524288;

  logic        Clk_i, Reset_n_i;
  logic [71:0] Window_i;
  logic        Valid_i, Ready_o, CoefWe_i, Valid_o, Ready_i, Busy_o;
  logic [3:0]  CoefAddr_i;
  logic [8:0]  CoefData_i, Mult1_o, Mult2_o;
  logic [19:0] Accum_o, Acc_o;
  logic [20:0] MacResult_i;
  logic [7:0]  Pixel_o;

  int total = 0;
  int bad   = 0;
  int mac_int;

  mac_window_sequencer #(.PIX_W(PIX_W), .MULT_SIZE(MULT_SIZE), .ACCUM_SIZE(ACCUM_SIZE)) dut (
    .Clk_i(Clk_i), .Reset_n_i(Reset_n_i), .Window_i(Window_i), .Valid_i(Valid_i),
    .Ready_o(Ready_o), .CoefWe_i(CoefWe_i), .CoefAddr_i(CoefAddr_i), .CoefData_i(CoefData_i),
    .Mult1_o(Mult1_o), .Mult2_o(Mult2_o), .Accum_o(Accum_o), .MacResult_i(MacResult_i),
    .Acc_o(Acc_o), .Pixel_o(Pixel_o), .Valid_o(Valid_o), .Ready_i(Ready_i), .Busy_o(Busy_o)
  );

  initial Clk_i = 1'b0;
  always #5 Clk_i = ~Clk_i;

  // External combinational MAC: Accum + Mult1*Mult2, all signed
  always_comb begin
    mac_int     = int'($signed(Accum_o)) + int'($signed(Mult1_o)) * int'($signed(Mult2_o));
    MacResult_i = 21'(mac_int);
  end

  // ---------------- reference model ----------------
  int m_coef [9];
  int m_win  [9];
  int m_phase;   // 0 idle, 1 computing, 2 result presented
  int m_tap;
  int m_exp_acc, m_exp_pix;
  bit m_live;
  bit m_rdy;

  function automatic int sat(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  // running sum of the first n taps, saturated after every tap
  function automatic int conv_taps(input int n);
    int a = 0;
    for (int k = 0; k < n; k++) a = sat(a + m_win[k] * m_coef[k]);
    return a;
  endfunction

  function automatic int clip_mag(input int a);
    int m = (a < 0) ? -a : a;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk_i) begin
    if (!Reset_n_i) begin
      m_live  = 1'b1;
      m_phase = 0;
      m_tap   = 0;
      m_coef  = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    end else if (m_live) begin
      m_rdy = (m_phase == 0) || (m_phase == 2 && Ready_i);
      if (m_phase == 0 && CoefWe_i && CoefAddr_i < 4'd9)
        m_coef[CoefAddr_i] = int'($signed(CoefData_i));
      if (m_phase == 1) begin
        m_tap++;
        if (m_tap == 9) m_phase = 2;
      end else if (m_phase == 2 && Ready_i) begin
        m_phase = 0;
      end
      if (m_rdy && Valid_i) begin
        for (int k = 0; k < 9; k++) m_win[k] = int'(Window_i[8*k +: 8]);
        m_exp_acc = conv_taps(9);
        m_exp_pix = clip_mag(m_exp_acc);
        m_phase   = 1;
        m_tap     = 0;
      end
    end
  end

  // Per-cycle compare, away from the active edge
  always @(negedge Clk_i) begin
    if (m_live) begin
      check("valid", int'(Valid_o), int'(m_phase == 2));
      check("busy", int'(Busy_o), int'(m_phase != 0));
      check("ready", int'(Ready_o), int'((m_phase == 0) || (m_phase == 2 && Ready_i)));
      if (m_phase == 2) begin
        check("acc", int'($signed(Acc_o)), m_exp_acc);
        check("pixel", int'(Pixel_o), m_exp_pix);
      end
      if (m_phase == 1) begin
        check("mult1", int'(Mult1_o), m_win[m_tap]);
        check("mult2", int'($signed(Mult2_o)), m_coef[m_tap]);
        check("accum", int'($signed(Accum_o)), conv_taps(m_tap));
      end else begin
        check("mult1_idle", int'(Mult1_o), 0);
        check("mult2_idle", int'(Mult2_o), 0);
        check("accum_idle", int'(Accum_o), 0);
      end
    end
  end

  // ---------------- directed + random stimulus ----------------
  task automatic step();
    @(posedge Clk_i);
    #2;
  endtask

  function automatic logic [71:0] mkwin(input int l, input int m, input int r);
    logic [71:0] w;
    for (int k = 0; k < 9; k++)
      w[8*k +: 8] = 8'((k % 3 == 0) ? l : (k % 3 == 1) ? m : r);
    return w;
  endfunction

  // lat = index (relative to acceptance edge) of the first edge sampling Valid_o high
  task automatic run_window(input logic [71:0] w, output int acc, output int pix, output int lat);
    int n = 0;
    Window_i = w;
    Valid_i  = 1'b1;
    Ready_i  = 1'b1;
    #1;
    while (!Ready_o && n < 50) begin step(); n++; end
    step();
    Valid_i = 1'b0;
    lat = 1;
    while (!Valid_o && lat < 40) begin step(); lat++; end
    if (!Valid_o) check("valid_timeout", 0, 1);
    acc = int'($signed(Acc_o));
    pix = int'(Pixel_o);
    step();
  endtask

  task automatic wait_valid(input string name, output int lat);
    lat = 1;
    while (!Valid_o && lat < 40) begin step(); lat++; end
    if (!Valid_o) check(name, 0, 1);
  endtask

  int a, p, l;

  initial begin
    Reset_n_i  = 1'b0;
    Window_i   = '0;
    Valid_i    = 1'b0;
    Ready_i    = 1'b0;
    CoefWe_i   = 1'b0;
    CoefAddr_i = '0;
    CoefData_i = '0;
    step();
    step();
    check("rst_valid", int'(Valid_o), 0);
    check("rst_busy", int'(Busy_o), 0);
    check("rst_ready", int'(Ready_o), 1);
    check("rst_acc", int'(Acc_o), 0);
    check("rst_pixel", int'(Pixel_o), 0);
    check("rst_mult1", int'(Mult1_o), 0);
    Reset_n_i = 1'b1;
    step();

    run_window(mkwin(100, 100, 100), a, p, l);
    check("flat_acc", a, 0);
    check("flat_pix", p, 0);
    check("flat_latency", l, 10);

    run_window(mkwin(0, 255, 255), a, p, l);
    check("left0_acc", a, 1020);
    check("left0_pix", p, 255);
    run_window(mkwin(255, 255, 0), a, p, l);
    check("right0_acc", a, -1020);
    check("right0_pix", p, 255);
    run_window(mkwin(0, 10, 10), a, p, l);
    check("small_acc", a, 40);
    check("small_pix", p, 40);

    for (int k = 0; k < 9; k++) begin
      CoefWe_i   = 1'b1;
      CoefAddr_i = 4'(k);
      CoefData_i = 9'd255;
      step();
    end
    CoefWe_i = 1'b0;
    run_window(mkwin(255, 255, 255), a, p, l);
    check("sat_acc", a, 524287);
    check("sat_pix", p, 255);

    // restore defaults
    Reset_n_i = 1'b0;
    step();
    Reset_n_i = 1'b1;
    step();

    // backpressure with a queued window
    Ready_i  = 1'b0;
    Window_i = mkwin(0, 10, 10);
    Valid_i  = 1'b1;
    step();
    Window_i = mkwin(255, 255, 0);
    wait_valid("bp_timeout", l);
    for (int i = 0; i < 5; i++) begin
      check("bp_acc", int'($signed(Acc_o)), 40);
      check("bp_pix", int'(Pixel_o), 40);
      check("bp_ready", int'(Ready_o), 0);
      check("bp_valid", int'(Valid_o), 1);
      step();
    end
    Ready_i = 1'b1;
    #1;
    check("bp_ready_hs", int'(Ready_o), 1);
    step();
    Valid_i = 1'b0;
    wait_valid("bp2_timeout", l);
    check("bp2_latency", l, 10);
    check("bp2_acc", int'($signed(Acc_o)), -1020);
    step();

    // writes during computation are dropped
    Window_i = mkwin(0, 255, 255);
    Valid_i  = 1'b1;
    step();
    Valid_i    = 1'b0;
    CoefWe_i   = 1'b1;
    CoefAddr_i = 4'd2;
    CoefData_i = 9'd5;
    step();
    step();
    step();
    CoefWe_i = 1'b0;
    wait_valid("runwr_timeout", l);
    check("runwr_acc", int'($signed(Acc_o)), 1020);
    step();

    // out-of-range address ignored
    CoefWe_i   = 1'b1;
    CoefAddr_i = 4'd12;
    CoefData_i = 9'd5;
    step();
    CoefWe_i = 1'b0;
    run_window(mkwin(0, 255, 255), a, p, l);
    check("addr12_acc", a, 1020);

    // write coincident with acceptance reaches tap 0
    Window_i   = mkwin(10, 0, 0);
    Valid_i    = 1'b1;
    CoefWe_i   = 1'b1;
    CoefAddr_i = 4'd0;
    CoefData_i = 9'd5;
    step();
    Valid_i  = 1'b0;
    CoefWe_i = 1'b0;
    wait_valid("accwr_timeout", l);
    check("accwr_acc", int'($signed(Acc_o)), 20);
    step();

    // reset mid-computation restores Sobel-X
    CoefWe_i   = 1'b1;
    CoefAddr_i = 4'd5;
    CoefData_i = 9'd0;
    step();
    CoefWe_i = 1'b0;
    Window_i = mkwin(0, 255, 255);
    Valid_i  = 1'b1;
    step();
    Valid_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    Reset_n_i = 1'b0;
    step();
    check("midrst_valid", int'(Valid_o), 0);
    check("midrst_ready", int'(Ready_o), 1);
    check("midrst_busy", int'(Busy_o), 0);
    check("midrst_mult1", int'(Mult1_o), 0);
    Reset_n_i = 1'b1;
    step();
    run_window(mkwin(0, 255, 255), a, p, l);
    check("midrst_coef_acc", a, 1020);

    // randomized traffic checked by the model
    for (int c = 0; c < 3000; c++) begin
      Reset_n_i = ($urandom_range(0, 599) != 0);
      Valid_i   = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 9; k++) Window_i[8*k +: 8] = 8'($urandom);
      Ready_i    = ($urandom_range(0, 9) < 6);
      CoefWe_i   = ($urandom_range(0, 9) == 0);
      CoefAddr_i = 4'($urandom_range(0, 15));
      CoefData_i = 9'($urandom);
      step();
    end
    Reset_n_i = 1'b1;
    Valid_i   = 1'b0;
    CoefWe_i  = 1'b0;
    Ready_i   = 1'b1;
    for (int i = 0; i < 15; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
